// File: rtl/irq_pkg.sv
// Shared constants and state type for the interrupt request encoder.
package irq_pkg;

    localparam int IRQ_N = 8;
    localparam int IRQ_W = 3;

    typedef enum logic {
        S_IDLE,
        S_PRESENT
    } irq_state_t;

endpackage

// File: rtl/irq_encoder_priority_encoder.sv
// Combinational lowest-bit-wins priority encoder; out is 0 when nothing is set.
module priority_encoder
    import irq_pkg::*;
#(
    parameter int N = IRQ_N,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] in,
    output logic [W-1:0] out,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        out = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                out = W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder.sv
// Registered interrupt priority encoder with sticky edge-captured pending
// bits and a valid/ack handshake toward the core.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | nothing presented; waits for ena and an eligible pending line
// S_PRESENT | valid=1, index frozen until the consumer acks
module irq_encoder
    import irq_pkg::*;
#(
    parameter int N = IRQ_N,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         ack,
    output logic         valid,
    output logic [W-1:0] index,
    output logic [N-1:0] pending,
    output logic         overflow
);

    irq_state_t   state_q;
    irq_state_t   state_nxt;
    logic [N-1:0] req_q;
    logic [N-1:0] pending_q;
    logic         overflow_q;
    logic [W-1:0] index_q;
    logic [N-1:0] rise;
    logic [N-1:0] clr;
    logic [N-1:0] sel;
    logic [W-1:0] enc_out;
    logic         enc_any;
    logic         load_index;

    assign rise = req & ~req_q;
    assign sel  = pending_q & mask;

    priority_encoder #(
        .N (N),
        .W (W)
    ) u_prio (
        .in  (sel),
        .out (enc_out),
        .any (enc_any)
    );

    // Clear mask for the acknowledged line; zero unless a presentation is accepted.
    always_comb begin
        clr = '0;
        if (state_q == S_PRESENT && ack) begin
            clr = N'(1) << index_q;
        end
    end

    // Edge capture, sticky pending (set beats clear) and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            req_q     <= req;
            pending_q <= (pending_q & ~clr) | rise;
            if ((rise & pending_q & ~clr) != '0) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // FSM next-state; ena only gates starting a new presentation.
    always_comb begin
        state_nxt  = state_q;
        load_index = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ena && enc_any) begin
                    state_nxt  = S_PRESENT;
                    load_index = 1'b1;
                end
            end
            S_PRESENT: begin
                if (ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Index is captured only on the entry into S_PRESENT and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            index_q <= '0;
        end else if (load_index) begin
            index_q <= enc_out;
        end
    end

    assign valid    = (state_q == S_PRESENT);
    assign index    = index_q;
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: doc/irq_encoder.md
# irq_encoder

Registered priority encoder that converts up to N one-hot-style request lines into a binary index with a valid/ack handshake. It is the inverse of the CPU's binary-to-one-hot decoders: peripherals raise lines and the core reads back a W-bit index. Requests are edge-captured into a sticky pending register. The index is held stable until the consumer acknowledges it. It sits between peripheral request wires and the RISC-V core's trap/CSR logic.

## Interface
- N, default 8: number of request lines, 2..32.
- W, default $clog2(N): index width.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; gates new presentations only.
- req  in  N  level request lines; a rising edge marks a line pending.
- mask  in  N  1 = line eligible for presentation.
- ack  in  1  consumer accepts the presented index; sampled only while valid=1.
- valid  out  1  index is presented.
- index  out  W  lowest-numbered eligible pending line; meaningful only when valid=1.
- pending  out  N  current pending register.
- overflow  out  1  sticky; a rising edge arrived on a line already pending.

## Operation
- Edge detect: req_q <= req every cycle. rise = req & ~req_q.
- Pending update each edge: pending <= (pending & ~clr) | rise.
  - clr is a one-hot of index when valid & ack, otherwise 0.
  - Set wins over clear on the same bit.
- Capture is independent of ena and mask; masked lines stay pending.
- Overflow: set when (rise & pending & ~clr) != 0. Cleared only by rst.
- Selection: sel = pending & mask. The lowest set bit of sel wins (bit 0 has highest priority).
- FSM states:
  - S_IDLE: valid=0. Moves to S_PRESENT when ena=1 and sel!=0; the priority result is registered into index on that edge.
  - S_PRESENT: valid=1 and index frozen. Changes to mask, ena, or new rises do not alter index or withdraw valid. On ack=1, the pending bit is cleared and the FSM returns to S_IDLE.
- ack in S_IDLE is ignored.
- A masked-out line is never presented. Unmasking it later makes it eligible with no new edge required.

## Timing
- Reset values: valid=0, index=0, pending=0, overflow=0, req_q=0, state=S_IDLE.
- A line held high through reset is captured as a rise on the first edge after rst falls.
- Latency: req rises before edge k, so pending[i]=1 after edge k and valid=1 with index=i after edge k+1.
- Handshake:
  - ack sampled high at edge m clears the bit; valid=0 after edge m.
  - Earliest next presentation is after edge m+1, so there is a minimum one-cycle valid gap between indices.
- Back-to-back: with 3 lines pending and ack held high, indices are presented every 2 cycles.
- rst asserted mid-presentation: all state returns to reset values at that edge. No ack is required.
- If ena is low while in S_PRESENT, the current presentation still completes on ack.
- If ena is low in S_IDLE, the FSM stays idle and pending keeps accumulating.

## Structure
- Package irq_pkg holds:
  - constants IRQ_N=8 and IRQ_W=3;
  - typedef enum logic {S_IDLE, S_PRESENT} irq_state_t.
- Sub-module priority_encoder: purely combinational. Inputs in[N-1:0]; outputs out[W-1:0] and any. Lowest set bit wins; out=0 when any=0. Unit-tested standalone.
- Top level contains the req_q/pending/overflow registers, the FSM, and the registered index.

## Test plan
- Reset: after rst, all outputs are 0. With req=8'h01 held through reset, valid=1 and index=0 appear 2 edges after rst falls.
- Priority/mask: pulse req=8'hA4 with mask=8'hFF. Acking each presentation yields indices 2, 5, 7, with valid low for 1 cycle between each. Pending ends at 0.
- Masked pending: mask=8'hF0, pulse req=8'h05. Valid stays 0 and pending=8'h05. Setting mask=8'hFF then presents index 0 after 1 edge.
- Set-beats-clear: present index 3, then assert ack in the same cycle req[3] rises again. Result: valid drops, pending[3] stays 1, overflow stays 0, and index 3 is re-presented.
- Overflow: raise req[1], drop it, raise it again before ack. Overflow=1 and stays 1 after the ack. Cleared only by rst.
- Frozen index and mid-op reset:
  - While index=4 is presented, raise req[0] and clear mask[4]. Index stays 4 until ack; then index 0 is presented.
  - Repeat, asserting rst instead of ack: valid=0 and pending=0 on the next edge.
